inst_loader: RTL and testbench

INST_LOADER -- requirements
Module: inst_loader

---
 rtl/inst_loader_pkg.sv | 17 +
 rtl/inst_loader_byte_packer.sv | 35 +++
 rtl/inst_loader.sv | 123 ++++++++++++
 tb/tb_inst_loader.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction loader: FSM encoding, session limits
// and word/byte geometry.
package inst_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_WRITE  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    localparam int MAX_WORDS_DEFAULT = 64;
    localparam int WORD_STEP         = 4;
    localparam int BYTE_IDX_W        = 2;
    localparam int CNT_W             = 7;

endpackage

// File: rtl/inst_loader_byte_packer.sv
// Assembles four little-endian bytes into a 32-bit word; word_full is the
// word as it will look once the current byte is shifted in.
module byte_packer
    import inst_loader_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        clr,
    input  logic        shift_en,
    input  logic [7:0]  in_byte,
    output logic [31:0] word_full,
    output logic        word_done
);

    logic [BYTE_IDX_W-1:0] idx_reg;
    logic [23:0]           shift_reg;

    // Bytes enter at the top and move down, so byte 0 ends in bits [7:0].
    assign word_full = {in_byte, shift_reg};
    assign word_done = shift_en && (idx_reg == '1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            idx_reg   <= '0;
            shift_reg <= '0;
        end else if (clr) begin
            idx_reg   <= '0;
            shift_reg <= '0;
        end else if (shift_en) begin
            idx_reg   <= idx_reg + 1'b1;
            shift_reg <= word_full[31:8];
        end
    end

endmodule

// File: rtl/inst_loader.sv
// Streams a program byte-by-byte into instruction memory while holding the
// CPU in reset; reports word count and XOR checksum of the session.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = MAX_WORDS_DEFAULT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [CNT_W-1:0]  LEN,
    input  logic [7:0]        IN_DATA,
    input  logic              IN_VALID,
    output logic              IN_READY,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [31:0]       MEM_DIN,
    output logic              MEM_WE,
    output logic              CPU_HOLD,
    output logic              BUSY,
    output logic              DONE,
    output logic [CNT_W-1:0]  WORD_CNT,
    output logic [31:0]       CHECKSUM
);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   target_reg;
    logic [CNT_W-1:0]   word_cnt_reg;
    logic [31:0]        checksum_reg;
    logic [31:0]        mem_din_reg;
    logic [ADDR_W-1:0]  mem_addr_reg;
    logic               start_accept;
    logic               byte_xfer;
    logic               word_done;
    logic [31:0]        word_full;

    assign start_accept = (state_reg == ST_IDLE) && START;
    assign byte_xfer    = IN_VALID && IN_READY;

    byte_packer u_packer (
        .CLK       (CLK),
        .RST       (RST),
        .clr       (start_accept),
        .shift_en  (byte_xfer),
        .in_byte   (IN_DATA),
        .word_full (word_full),
        .word_done (word_done)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        IN_READY   = 1'b0;
        MEM_WE     = 1'b0;
        BUSY       = 1'b0;
        CPU_HOLD   = 1'b1;
        DONE       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                CPU_HOLD = 1'b0;
                if (START) begin
                    state_next = (LEN == '0) ? ST_FINISH : ST_LOAD;
                end
            end
            ST_LOAD: begin
                IN_READY = 1'b1;
                BUSY     = 1'b1;
                if (word_done) begin
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                MEM_WE = 1'b1;
                BUSY   = 1'b1;
                state_next = (word_cnt_reg + 1'b1 == target_reg) ? ST_FINISH : ST_LOAD;
            end
            ST_FINISH: begin
                DONE       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            target_reg   <= '0;
            word_cnt_reg <= '0;
            checksum_reg <= '0;
            mem_din_reg  <= '0;
            mem_addr_reg <= '0;
        end else begin
            if (start_accept) begin
                target_reg   <= (LEN > CNT_W'(MAX_WORDS)) ? CNT_W'(MAX_WORDS) : LEN;
                word_cnt_reg <= '0;
                checksum_reg <= '0;
                mem_addr_reg <= '0;
            end
            // Data and address are captured with the last byte so they hold after the write.
            if (word_done) begin
                mem_din_reg  <= word_full;
                mem_addr_reg <= ADDR_W'(32'(word_cnt_reg) * 32'(WORD_STEP));
            end
            if (state_reg == ST_WRITE) begin
                word_cnt_reg <= word_cnt_reg + 1'b1;
                checksum_reg <= checksum_reg ^ mem_din_reg;
            end
        end
    end

    assign MEM_ADDR = mem_addr_reg;
    assign MEM_DIN  = mem_din_reg;
    assign WORD_CNT = word_cnt_reg;
    assign CHECKSUM = checksum_reg;

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: expected memory writes are queued as words
// are streamed and popped by a monitor whenever MEM_WE is seen.
module tb_inst_loader;
    import inst_loader_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic [6:0]  LEN = '0;
    logic [7:0]  IN_DATA = '0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [7:0]  MEM_ADDR;
    logic [31:0] MEM_DIN;
    logic        MEM_WE;
    logic        CPU_HOLD;
    logic        BUSY;
    logic        DONE;
    logic [6:0]  WORD_CNT;
    logic [31:0] CHECKSUM;

    inst_loader #(.ADDR_W(8), .MAX_WORDS(64)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .LEN      (LEN),
        .IN_DATA  (IN_DATA),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .MEM_ADDR (MEM_ADDR),
        .MEM_DIN  (MEM_DIN),
        .MEM_WE   (MEM_WE),
        .CPU_HOLD (CPU_HOLD),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .WORD_CNT (WORD_CNT),
        .CHECKSUM (CHECKSUM)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  we_count = 0;
    int  ready_count = 0;
    int  hold_low = 0;
    bit  hold_watch = 0;
    logic [7:0]  last_addr = '0;
    logic [31:0] exp_sum;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
        end
    endtask

    // Scoreboard consumer plus cycle counters, sampled mid-cycle.
    always @(negedge CLK) begin
        if (MEM_WE) begin
            wr_t e;
            we_count++;
            last_addr = MEM_ADDR;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", {24'd0, MEM_ADDR}, {24'd0, e.addr});
                check("wr_data", MEM_DIN, e.data);
                $display("write addr=0x%02h data=0x%08h", MEM_ADDR, MEM_DIN);
            end
        end
        if (IN_READY) ready_count++;
        if (hold_watch && !CPU_HOLD) hold_low++;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_session(input logic [6:0] len);
        START = 1'b1;
        LEN   = len;
        step();
        START = 1'b0;
        LEN   = 7'h55;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        IN_DATA  = b;
        IN_VALID = 1'b1;
        @(negedge CLK);
        while (!IN_READY && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 200) check("ready_timeout", 32'd0, 32'd1);
        step();
        IN_VALID = 1'b0;
        repeat (gap) step();
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
    endtask

    task automatic wait_done(input int max_cycles);
        bit seen = 0;
        for (int n = 0; n < max_cycles && !seen; n++) begin
            @(negedge CLK);
            if (DONE) seen = 1;
        end
        check("done_seen", {31'd0, seen}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;

        // Reset state
        @(negedge CLK);
        check("rst_ctrl", {27'd0, IN_READY, MEM_WE, CPU_HOLD, BUSY, DONE}, 32'd0);
        check("rst_addr_din", MEM_DIN | {24'd0, MEM_ADDR}, 32'd0);
        check("rst_cnt_sum", CHECKSUM | {25'd0, WORD_CNT}, 32'd0);
        step();
        RST = 1'b0;
        step();

        // Single word, continuous stream, exact write/done timing
        exp_q.push_back('{8'h00, 32'h12345678});
        start_session(7'd1);
        send_byte(8'h78, 0);
        send_byte(8'h56, 0);
        send_byte(8'h34, 0);
        send_byte(8'h12, 0);
        @(negedge CLK);
        check("t1_we", {31'd0, MEM_WE}, 32'd1);
        check("t1_din", MEM_DIN, 32'h12345678);
        @(negedge CLK);
        check("t1_done", {31'd0, DONE}, 32'd1);
        check("t1_cnt", {25'd0, WORD_CNT}, 32'd1);
        check("t1_sum", CHECKSUM, 32'h12345678);
        $display("session len=1 cnt=%0d sum=0x%08h", WORD_CNT, CHECKSUM);
        step();

        // Two words with gaps; CPU_HOLD must stay high through DONE
        we_count = 0;
        hold_low = 0;
        exp_q.push_back('{8'h00, 32'hFFFF0000});
        exp_q.push_back('{8'h04, 32'h0000FFFF});
        start_session(7'd2);
        hold_watch = 1;
        send_word(32'hFFFF0000, 1);
        send_word(32'h0000FFFF, 1);
        wait_done(20);
        hold_watch = 0;
        check("t2_writes", we_count, 32'd2);
        check("t2_sum", CHECKSUM, 32'hFFFFFFFF);
        check("t2_cnt", {25'd0, WORD_CNT}, 32'd2);
        check("t2_hold", hold_low, 32'd0);
        $display("session len=2 cnt=%0d sum=0x%08h", WORD_CNT, CHECKSUM);
        step();

        // Zero-length session
        we_count = 0;
        ready_count = 0;
        start_session(7'd0);
        @(negedge CLK);
        check("t3_done", {31'd0, DONE}, 32'd1);
        step();
        step();
        check("t3_writes", we_count, 32'd0);
        check("t3_ready", ready_count, 32'd0);
        check("t3_cnt", {25'd0, WORD_CNT}, 32'd0);
        $display("session len=0 cnt=%0d", WORD_CNT);

        // Oversized LEN clamps to 64 words, last address 0xFC
        we_count = 0;
        exp_sum = '0;
        start_session(7'd100);
        for (int i = 0; i < 64; i++) begin
            w = (32'h01020304 * (i + 1)) ^ 32'hA5A50000;
            exp_q.push_back('{8'(i * 4), w});
            exp_sum = exp_sum ^ w;
            send_word(w, 0);
        end
        wait_done(10);
        check("t4_writes", we_count, 32'd64);
        check("t4_last_addr", {24'd0, last_addr}, 32'h000000FC);
        check("t4_cnt", {25'd0, WORD_CNT}, 32'd64);
        check("t4_sum", CHECKSUM, exp_sum);
        ready_count = 0;
        IN_VALID = 1'b1;
        repeat (5) step();
        IN_VALID = 1'b0;
        check("t4_ready_after", ready_count, 32'd0);
        $display("session len=100 cnt=%0d sum=0x%08h", WORD_CNT, CHECKSUM);

        // Reset mid-session drops the partial word
        we_count = 0;
        exp_q.push_back('{8'h00, 32'hCAFEF00D});
        start_session(7'd2);
        send_word(32'hCAFEF00D, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        RST = 1'b1;
        @(negedge CLK);
        check("t5_rst_ctrl", {27'd0, IN_READY, MEM_WE, CPU_HOLD, BUSY, DONE}, 32'd0);
        check("t5_rst_addr_din", MEM_DIN | {24'd0, MEM_ADDR}, 32'd0);
        check("t5_rst_cnt_sum", CHECKSUM | {25'd0, WORD_CNT}, 32'd0);
        step();
        RST = 1'b0;
        step();
        check("t5_writes", we_count, 32'd1);
        check("t5_q_empty", exp_q.size(), 32'd0);
        exp_q.push_back('{8'h00, 32'h0BADBEEF});
        start_session(7'd1);
        send_word(32'h0BADBEEF, 0);
        wait_done(10);
        check("t5_restart_cnt", {25'd0, WORD_CNT}, 32'd1);
        $display("session reset/restart cnt=%0d sum=0x%08h", WORD_CNT, CHECKSUM);
        step();

        // START during LOAD is ignored
        we_count = 0;
        exp_q.push_back('{8'h00, 32'h89ABCDEF});
        exp_q.push_back('{8'h04, 32'h01234567});
        start_session(7'd2);
        send_byte(8'hEF, 0);
        send_byte(8'hCD, 0);
        START = 1'b1;
        LEN   = 7'd5;
        step();
        START = 1'b0;
        send_byte(8'hAB, 0);
        send_byte(8'h89, 0);
        send_word(32'h01234567, 0);
        wait_done(10);
        check("t6_writes", we_count, 32'd2);
        check("t6_cnt", {25'd0, WORD_CNT}, 32'd2);
        check("t6_sum", CHECKSUM, 32'h89ABCDEF ^ 32'h01234567);
        step();
        check("t6_idle", {30'd0, BUSY, CPU_HOLD}, 32'd0);
        check("t6_q_empty", exp_q.size(), 32'd0);
        $display("session ignored-start cnt=%0d sum=0x%08h", WORD_CNT, CHECKSUM);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
